// File: rtl/output_packetizer.sv
// Output packetizer: holds back one 64-bit word so the word can be written with the correct
// pkt_end flag. A packet closes on the word-count limit, an idle timeout or a flush request.
module output_packetizer #(
   parameter int unsigned MAX_PKT_WORDS = 256,
   parameter int unsigned IDLE_TIMEOUT  = 1024,
   parameter int unsigned PKT_CNT_WIDTH = 16
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [63:0]              din,
   input  logic                     din_wr,
   output logic                     din_full,
   input  logic                     flush,
   output logic [63:0]              dout,
   output logic                     wr_en,
   input  logic                     full,
   output logic                     pkt_end,
   output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

   localparam int unsigned WordCntW = $clog2(MAX_PKT_WORDS);
   localparam int unsigned IdleCntW = $clog2(IDLE_TIMEOUT);
   localparam logic [WordCntW-1:0] WordLast = WordCntW'(MAX_PKT_WORDS - 1);
   localparam logic [IdleCntW-1:0] IdleLast = IdleCntW'(IDLE_TIMEOUT - 1);

   if (MAX_PKT_WORDS < 2) begin : g_bad_max
      $error("MAX_PKT_WORDS must be at least 2");
   end
   if (IDLE_TIMEOUT < 2) begin : g_bad_idle
      $error("IDLE_TIMEOUT must be at least 2");
   end

   logic [63:0]         hold_data;
   logic                hold_valid;
   logic [WordCntW-1:0] word_cnt;
   logic [IdleCntW-1:0] idle_cnt;

   logic cnt_last;
   logic tmo;
   logic close;
   logic accept;
   logic emit;

   // Handshake outputs are forced low while RESET is asserted, whatever the held state.
   always_comb begin
      cnt_last = (word_cnt == WordLast);
      tmo      = (idle_cnt == IdleLast);
      close    = cnt_last || tmo || flush;
      din_full = !RESET && hold_valid && full;
      accept   = din_wr && !din_full;
      emit     = !RESET && hold_valid && !full && (accept || close);
      wr_en    = emit;
      pkt_end  = emit && close;
      dout     = hold_data;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hold_valid <= 1'b0;
         word_cnt   <= '0;
         idle_cnt   <= '0;
         pkt_cnt    <= '0;
      end else begin
         if (accept) begin
            hold_valid <= 1'b1;
         end else if (emit) begin
            hold_valid <= 1'b0;
         end

         if (emit) begin
            word_cnt <= pkt_end ? '0 : word_cnt + WordCntW'(1);
         end

         // Saturation keeps a timeout pending while the output FIFO is full.
         if (accept || !hold_valid) begin
            idle_cnt <= '0;
         end else if (!tmo) begin
            idle_cnt <= idle_cnt + IdleCntW'(1);
         end

         if (pkt_end) begin
            pkt_cnt <= pkt_cnt + PKT_CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_data <= din;
      end
   end

endmodule

// File: tb/tb_output_packetizer.sv
// Directed self-checking bench for output_packetizer with default parameters (256 / 1024).
module tb_output_packetizer;

   logic        CLK;
   logic        RESET;
   logic [63:0] din;
   logic        din_wr;
   logic        din_full;
   logic        flush;
   logic [63:0] dout;
   logic        wr_en;
   logic        full;
   logic        pkt_end;
   logic [15:0] pkt_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [63:0] wq[$];
   logic        eq[$];
   int          cq[$];

   output_packetizer dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .din      (din),
      .din_wr   (din_wr),
      .din_full (din_full),
      .flush    (flush),
      .dout     (dout),
      .wr_en    (wr_en),
      .full     (full),
      .pkt_end  (pkt_end),
      .pkt_cnt  (pkt_cnt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every output FIFO write with the cycle it happened in.
   always @(negedge CLK) begin
      if (wr_en) begin
         wq.push_back(dout);
         eq.push_back(pkt_end);
         cq.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET  = 1'b1;
      din_wr = 1'b0;
      flush  = 1'b0;
      full   = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_pkt_end", 64'(pkt_end), 64'd0);
      check("rst_din_full", 64'(din_full), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      wq.delete();
      eq.delete();
      cq.delete();
   endtask

   // Present one word and keep din_wr high until it is accepted; returns its load cycle.
   task automatic put(input logic [63:0] d, output int ld);
      bit ok;
      ok     = 1'b0;
      din    = d;
      din_wr = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge CLK);
         ok = !din_full;
         @(posedge CLK);
         #1;
      end
      check("put_accept", 64'(ok), 64'd1);
      ld = cyc;
   endtask

   task automatic wait_writes(input string tag, input int n, input int bound);
      for (int i = 0; i < bound && wq.size() < n; i++) begin
         @(posedge CLK);
         #1;
      end
      check(tag, 64'(wq.size()), 64'(n));
   endtask

   initial begin
      int ld;
      int ld2;
      int lds[600];
      int ends;

      din    = '0;
      din_wr = 1'b0;
      flush  = 1'b0;
      full   = 1'b0;
      RESET  = 1'b1;

      // Single word closes by idle timeout 1023 cycles after load.
      do_reset();
      put(64'h1122334455667788, ld);
      din_wr = 1'b0;
      wait_writes("t1_writes", 1, 1100);
      check("t1_data", wq[0], 64'h1122334455667788);
      check("t1_end", 64'(eq[0]), 64'd1);
      check("t1_cycle", 64'(cq[0]), 64'(ld + 1023));
      check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // 600-word burst: ends on indices 255, 511 (count limit) and 599 (timeout).
      do_reset();
      for (int i = 0; i < 600; i++) put(64'(i), lds[i]);
      din_wr = 1'b0;
      wait_writes("t2_writes", 600, 1100);
      ends = 0;
      for (int i = 0; i < wq.size(); i++) begin
         check("t2_data", wq[i], 64'(i));
         check("t2_end", 64'(eq[i]), 64'(i == 255 || i == 511 || i == 599));
         ends += int'(eq[i]);
      end
      check("t2_end_total", 64'(ends), 64'd3);
      check("t2_cyc255", 64'(cq[255]), 64'(lds[255]));
      check("t2_cyc511", 64'(cq[511]), 64'(lds[511]));
      check("t2_cyc599", 64'(cq[599]), 64'(lds[599] + 1023));
      check("t2_pkt_cnt", 64'(pkt_cnt), 64'd3);

      // 10 words with the output FIFO full for 50 cycles after word 4.
      do_reset();
      for (int i = 0; i < 5; i++) put(64'(100 + i), ld);
      full = 1'b1;
      din  = 64'd105;
      check("t3_pre_full_writes", 64'(wq.size()), 64'd4);
      @(negedge CLK);
      check("t3_din_full", 64'(din_full), 64'd1);
      repeat (50) begin
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      check("t3_din_full_late", 64'(din_full), 64'd1);
      check("t3_no_write_full", 64'(wq.size()), 64'd4);
      @(posedge CLK);
      #1;
      full = 1'b0;
      for (int i = 5; i < 10; i++) put(64'(100 + i), ld);
      din_wr = 1'b0;
      wait_writes("t3_writes", 10, 1100);
      for (int i = 0; i < wq.size(); i++) begin
         check("t3_data", wq[i], 64'(100 + i));
         check("t3_end", 64'(eq[i]), 64'(i == 9));
      end
      check("t3_cyc9", 64'(cq[9]), 64'(ld + 1023));
      check("t3_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // Flush pulse while word 2 is held, then flush with nothing held.
      do_reset();
      put(64'hA0, ld);
      put(64'hA1, ld);
      put(64'hA2, ld);
      din_wr = 1'b0;
      flush  = 1'b1;
      @(posedge CLK);
      #1;
      flush = 1'b0;
      check("t4_writes", 64'(wq.size()), 64'd3);
      check("t4_data2", wq[2], 64'hA2);
      check("t4_end0", 64'(eq[0]), 64'd0);
      check("t4_end1", 64'(eq[1]), 64'd0);
      check("t4_end2", 64'(eq[2]), 64'd1);
      check("t4_cyc2", 64'(cq[2]), 64'(ld));
      flush = 1'b1;
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      flush = 1'b0;
      check("t4_empty_flush_writes", 64'(wq.size()), 64'd3);
      check("t4_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // New word arrives in the very cycle the held word times out.
      do_reset();
      put(64'hBEEF, ld);
      din_wr = 1'b0;
      repeat (1023) begin
         @(posedge CLK);
         #1;
      end
      put(64'hCAFE, ld2);
      din_wr = 1'b0;
      check("t5_writes", 64'(wq.size()), 64'd1);
      check("t5_old_data", wq[0], 64'hBEEF);
      check("t5_old_end", 64'(eq[0]), 64'd1);
      check("t5_old_cyc", 64'(cq[0]), 64'(ld + 1023));
      check("t5_word_cnt", 64'(dut.word_cnt), 64'd0);
      check("t5_idle_cnt", 64'(dut.idle_cnt), 64'd0);
      wait_writes("t5_writes2", 2, 1100);
      check("t5_new_data", wq[1], 64'hCAFE);
      check("t5_new_end", 64'(eq[1]), 64'd1);
      check("t5_new_cyc", 64'(cq[1]), 64'(ld2 + 1023));
      check("t5_pkt_cnt", 64'(pkt_cnt), 64'd2);

      // Reset mid-packet discards the held word; flush is high to expose ungated writes.
      do_reset();
      for (int i = 0; i < 5; i++) put(64'(200 + i), ld);
      din_wr = 1'b0;
      check("t6_pre_writes", 64'(wq.size()), 64'd4);
      RESET = 1'b1;
      flush = 1'b1;
      @(negedge CLK);
      check("t6_rst_wr_en", 64'(wr_en), 64'd0);
      check("t6_rst_pkt_end", 64'(pkt_end), 64'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      flush = 1'b0;
      check("t6_pkt_cnt_rst", 64'(pkt_cnt), 64'd0);
      check("t6_word_cnt_rst", 64'(dut.word_cnt), 64'd0);
      check("t6_hold_valid_rst", 64'(dut.hold_valid), 64'd0);
      put(64'hD00D, ld);
      din_wr = 1'b0;
      wait_writes("t6_writes", 5, 1100);
      check("t6_data", wq[4], 64'hD00D);
      check("t6_end", 64'(eq[4]), 64'd1);
      check("t6_cyc", 64'(cq[4]), 64'(ld + 1023));
      check("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
